// File: rtl/fm_tdm_pkg.sv
// Shared definitions for the time-multiplexed FM modulator.
//   cfg_sel_e    : configuration register select (carrier / deviation)
//   LFSR_POLY    : Galois mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   LFSR_SEED    : phase-dither LFSR start value
//   chan_bits()  : channel index width for a given channel count
//   sine_entry() : elaboration-time quarter-wave sine table entry
package fm_tdm_pkg;

    typedef enum logic {
        CFG_CARR = 1'b0,
        CFG_DEV  = 1'b1
    } cfg_sel_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // round(amp * sin(i * (pi/2) / 2^lw)), evaluated with a Q30 Taylor series
    // so the table needs no real arithmetic at elaboration.
    function automatic int sine_entry(input int i, input int lw, input int amp);
        longint x, x2, term, acc;
        x    = (longint'(i) * 64'sd1686629713) >>> lw;   // pi/2 in Q30
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 7; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return int'((acc * longint'(amp) + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/fm_sine_lut.sv
// Quarter-wave sine table with quadrant fold/unfold and one registered read.
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : read enable; output register holds while low
//   phase      : LW+2 phase bits (2 quadrant bits + LW table index)
//   data       : signed Q1.(DW-1) sine sample, amplitude 2^(DW-1)-1
module fm_sine_lut
    import fm_tdm_pkg::*;
#(
    parameter int DW = 12,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic [LW+1:0] phase,
    output logic [DW-1:0] data
);

    localparam int DEPTH = 2 ** LW;
    localparam int AMP   = 2 ** (DW - 1) - 1;

    logic [DW-2:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DW-2:0] ENTRY = (DW - 1)'(sine_entry(i, LW, AMP));
        assign rom[i] = ENTRY;
    end

    logic [1:0]    quad;
    logic [LW-1:0] idx;
    logic [LW-1:0] addr;
    logic          peak;
    logic [DW-2:0] mag;
    logic [DW-1:0] val;

    // Odd quadrants mirror the index; index 0 there is the crest, which the
    // 2^LW-entry table cannot address, so it is supplied directly.
    always_comb begin
        quad = phase[LW+1:LW];
        idx  = phase[LW-1:0];
        peak = quad[0] && (idx == '0);
        addr = quad[0] ? -idx : idx;
        mag  = peak ? (DW - 1)'(AMP) : rom[addr];
        val  = {1'b0, mag};
        // magnitude never exceeds AMP, so the negative peak is -(2^(DW-1)-1)
        if (quad[1]) begin
            val = -val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (adv) begin
            data <= val;
        end
    end

endmodule

// File: rtl/fm_mod_tdm.sv
// Time-multiplexed CH-channel FM modulator sharing one multiplier, one phase
// adder and one sine table. Channels are issued round-robin; output is a TDM
// stream with ready/valid backpressure.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : global enable (low freezes all state)
//   cfg_we/ch/sel/data  : per-channel carrier (sel=0) / deviation (sel=1) write
//   in_valid/ready/ch/data : per-channel modulation hold-register write
//   out_valid/ready/ch/data : FM sample stream, Q1.(DW-1)
// Build option: define FM_PHASE_DITHER_EN to add LFSR phase dither before the
// table-address truncation; otherwise plain truncation.
module fm_mod_tdm
    import fm_tdm_pkg::*;
#(
    parameter  int DW  = 12,
    parameter  int PW  = 24,
    parameter  int CH  = 4,
    parameter  int LW  = 10,
    localparam int CHW = chan_bits(CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic                 cfg_sel,
    input  logic signed [PW-1:0] cfg_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch,
    output logic signed [DW-1:0] out_data
);

    logic signed [DW-1:0] mod_reg   [CH];
    logic signed [PW-1:0] carr      [CH];
    logic signed [PW-1:0] dev       [CH];
    logic [PW-1:0]        phase_acc [CH];

    logic                 adv;
    logic [CHW-1:0]       issue_ch;

    logic                     v1, v2, v3;
    logic [CHW-1:0]           ch1, ch2, ch3;
    logic signed [DW+PW-1:0]  prod1;
    logic signed [PW-1:0]     carr1;
    logic [PW-1:0]            freq2;
    logic [PW-1:0]            ph3;

    logic signed [DW-1:0]     m_sel;
    logic signed [PW-1:0]     d_sel;
    logic signed [DW+PW-1:0]  prod_c;
    logic [PW-1:0]            freq_c;
    logic [PW-1:0]            ph_q;
    logic [LW+1:0]            lut_phase;

    assign in_ready = en;
    assign adv      = en && (!out_valid || out_ready);

    // Hold registers and configuration; written independently of stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH; i++) begin
                mod_reg[i] <= '0;
                carr[i]    <= '0;
                dev[i]     <= '0;
            end
        end else begin
            if (in_valid && en && (int'(in_ch) < CH)) begin
                mod_reg[in_ch] <= in_data;
            end
            if (cfg_we && en && (int'(cfg_ch) < CH)) begin
                if (cfg_sel_e'(cfg_sel) == CFG_DEV) begin
                    dev[cfg_ch] <= cfg_data;
                end else begin
                    carr[cfg_ch] <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        m_sel  = mod_reg[issue_ch];
        d_sel  = dev[issue_ch];
        prod_c = (DW + PW)'(m_sel) * (DW + PW)'(d_sel);
        freq_c = PW'(prod1 >>> (DW - 1)) + carr1;
    end

    // Carrier is captured at issue alongside the product so a configuration
    // write never reaches a sample already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_ch  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            ch1       <= '0;
            ch2       <= '0;
            ch3       <= '0;
            prod1     <= '0;
            carr1     <= '0;
            freq2     <= '0;
            ph3       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
        end else if (adv) begin
            issue_ch  <= (issue_ch == CHW'(CH - 1)) ? '0 : issue_ch + CHW'(1);
            v1        <= 1'b1;
            ch1       <= issue_ch;
            prod1     <= prod_c;
            carr1     <= carr[issue_ch];
            v2        <= v1;
            ch2       <= ch1;
            freq2     <= freq_c;
            v3        <= v2;
            ch3       <= ch2;
            ph3       <= phase_acc[ch2];
            out_valid <= v3;
            out_ch    <= ch3;
        end
    end

    // Round-robin with CH>=2 keeps the same channel out of consecutive
    // stages, so read-then-update of one accumulator needs no forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH; i++) begin
                phase_acc[i] <= '0;
            end
        end else if (adv && v2) begin
            phase_acc[ch2] <= phase_acc[ch2] + freq2;
        end
    end

`ifdef FM_PHASE_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (adv) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : '0);
        end
    end

    always_comb begin
        ph_q = ph3 + PW'(lfsr[PW-LW-3:0]);
    end
`else
    always_comb begin
        ph_q = ph3;
    end
`endif

    always_comb begin
        lut_phase = (LW + 2)'(ph_q >> (PW - LW - 2));
    end

    fm_sine_lut #(
        .DW (DW),
        .LW (LW)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv),
        .phase (lut_phase),
        .data  (out_data)
    );

endmodule
